// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state names, oversampling default
// and frame layout constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OVS_DEFAULT = 16;
  localparam int DATA_BITS   = 8;
  localparam int STOP_BITS   = 1;

endpackage

// File: rtl/uart_rx_if.sv
// Result bus from the UART receiver to the APB register wrapper, plus the FSM state
// for observation.
interface uart_rx_if;
  import uart_pkg::*;

  // o_rx_done and o_frame_err are one-clk strobes with no ready/backpressure: the
  // consumer must capture o_rx_data in the same cycle o_rx_done is high.
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_rx_done;
  logic                 o_frame_err;
  logic                 o_rx_busy;
  logic [1:0]           state;

  modport master (output o_rx_data, o_rx_done, o_frame_err, o_rx_busy, state);
  modport slave  (input  o_rx_data, o_rx_done, o_frame_err, o_rx_busy, state);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable
// reset value so idle-high lines do not produce a false edge after reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a shared oversampling tick; samples each bit at its
// midpoint and reports a received byte or a framing error as a one-clk pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS = OVS_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      tick,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  localparam logic [TW-1:0] MID_CNT  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_d;
  logic                 start_edge;

  logic [1:0]           state,     state_n;
  logic [TW-1:0]        tick_cnt,  tick_cnt_n;
  logic [BW-1:0]        bit_cnt,   bit_cnt_n;
  logic [DATA_BITS-1:0] shift_reg, shift_reg_n;
  logic [DATA_BITS-1:0] rx_data,   rx_data_n;
  logic                 rx_done,   rx_done_n;
  logic                 frame_err, frame_err_n;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Only a real 1->0 transition arms the receiver, so a line held low never re-triggers.
  assign start_edge = rx_d & ~rx_s;

  always_comb begin
    state_n     = state;
    tick_cnt_n  = tick_cnt;
    bit_cnt_n   = bit_cnt;
    shift_reg_n = shift_reg;
    rx_data_n   = rx_data;
    rx_done_n   = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_n    = S_START;
          tick_cnt_n = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt == MID_CNT) begin
            tick_cnt_n = '0;
            bit_cnt_n  = '0;
            state_n    = rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt == LAST_CNT) begin
            tick_cnt_n  = '0;
            shift_reg_n = {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state_n = S_STOP;
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tick_cnt == LAST_CNT) begin
            tick_cnt_n = '0;
            state_n    = S_IDLE;
            if (rx_s) begin
              rx_data_n = shift_reg;
              rx_done_n = 1'b1;
            end else begin
              frame_err_n = 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_d      <= 1'b1;
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_d      <= rx_s;
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_reg_n;
      rx_data   <= rx_data_n;
      rx_done   <= rx_done_n;
      frame_err <= frame_err_n;
    end
  end

  assign bus.o_rx_data   = rx_data;
  assign bus.o_rx_done   = rx_done;
  assign bus.o_frame_err = frame_err;
  assign bus.o_rx_busy   = (state != S_IDLE);
  assign bus.state       = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives 8N1 frames on rx with a tick every 4 clk and compares
// the received bytes and error pulses against the frames it sent.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;  // 16 ticks x 4 clk

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic rx = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.OVS(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .rx   (rx),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         ferr_seen = 0;
  int         both_seen = 0;
  logic [7:0] last_data = 8'h00;

  // ---------------- clock / tick ----------------
  always #5 clk = ~clk;

  initial begin : tick_gen
    int tc;
    tc = 0;
    forever begin
      @(negedge clk);
      tick = (tc == 3);
      tc = (tc + 1) % 4;
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_rx_done) obs_q.push_back(bus.o_rx_data);
      if (bus.o_frame_err) ferr_seen++;
      if (bus.o_rx_done && bus.o_frame_err) both_seen++;
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic v, input int n);
    @(negedge clk);
    rx = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int bclks);
    drive_bit(1'b0, bclks);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bclks);
    drive_bit(stop_v, bclks);
  endtask

  task automatic send_good(input logic [7:0] b, input int bclks);
    send_frame(b, 1'b1, bclks);
    exp_q.push_back(b);
    last_data = b;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    ferr_seen = 0;
    both_seen = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.o_rx_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.o_rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout: busy=%b required 0", name, bus.o_rx_busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus.o_rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h required 00", bus.o_rx_data); end
    if (bus.o_rx_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", bus.o_rx_done); end
    if (bus.o_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b required 0", bus.o_frame_err); end
    if (bus.o_rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", bus.o_rx_busy); end
    rst = 1'b0;
    last_data = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_valid_frame();
    clear_sb();
    send_good(8'hA5, BIT_CLKS);
    wait_idle("valid");
    for (int i = 0; i < 3; i++) begin
      send_good(8'($urandom_range(0, 255)), BIT_CLKS);
      repeat ($urandom_range(0, 100)) @(negedge clk);
    end
    wait_idle("valid");
    checks += 3;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL valid_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    if (ferr_seen !== 0) begin failures++; $display("FAIL valid_ferr: got %0d required 0", ferr_seen); end
    if (bus.o_rx_data !== last_data) begin failures++; $display("FAIL valid_hold: got %h required %h", bus.o_rx_data, last_data); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL valid_byte%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_glitch();
    clear_sb();
    @(negedge clk);
    rx = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (bus.o_rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_armed: busy=%b required 1", bus.o_rx_busy); end
    rx = 1'b1;
    wait_idle("glitch");
    checks += 3;
    if (obs_q.size() !== 0) begin failures++; $display("FAIL glitch_done: got %0d pulses required 0", obs_q.size()); end
    if (ferr_seen !== 0) begin failures++; $display("FAIL glitch_ferr: got %0d required 0", ferr_seen); end
    if (bus.o_rx_data !== last_data) begin failures++; $display("FAIL glitch_hold: got %h required %h", bus.o_rx_data, last_data); end
  endtask

  task automatic test_frame_err();
    logic [7:0] b;
    clear_sb();
    send_frame(8'h3C, 1'b0, BIT_CLKS);
    repeat (3 * BIT_CLKS) @(negedge clk);  // rx still low: must not re-arm
    checks += 5;
    if (ferr_seen !== 1) begin failures++; $display("FAIL ferr_count: got %0d required 1", ferr_seen); end
    if (obs_q.size() !== 0) begin failures++; $display("FAIL ferr_done: got %0d pulses required 0", obs_q.size()); end
    if (both_seen !== 0) begin failures++; $display("FAIL ferr_both: got %0d required 0", both_seen); end
    if (bus.o_rx_data !== last_data) begin failures++; $display("FAIL ferr_hold: got %h required %h", bus.o_rx_data, last_data); end
    if (bus.o_rx_busy !== 1'b0) begin failures++; $display("FAIL ferr_rearm: busy=%b required 0", bus.o_rx_busy); end
    drive_bit(1'b1, BIT_CLKS);
    b = 8'($urandom_range(0, 255));
    send_good(b, BIT_CLKS);
    wait_idle("ferr");
    checks += 3;
    if (ferr_seen !== 1) begin failures++; $display("FAIL ferr_after: got %0d required 1", ferr_seen); end
    if (obs_q.size() !== 1) begin failures++; $display("FAIL ferr_recover_count: got %0d required 1", obs_q.size()); end
    else if (obs_q[0] !== b) begin failures++; $display("FAIL ferr_recover_byte: got %h required %h", obs_q[0], b); end
    if (bus.o_rx_data !== b) begin failures++; $display("FAIL ferr_recover_hold: got %h required %h", bus.o_rx_data, b); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[5];
    clear_sb();
    seq[0] = 8'h00;
    seq[1] = 8'hFF;
    seq[2] = 8'h55;
    seq[3] = 8'($urandom_range(0, 255));
    seq[4] = 8'($urandom_range(0, 255));
    foreach (seq[i]) send_good(seq[i], BIT_CLKS);
    wait_idle("b2b");
    checks += 2;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    if (ferr_seen !== 0) begin failures++; $display("FAIL b2b_ferr: got %0d required 0", ferr_seen); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_baud_tolerance();
    int periods[2];
    clear_sb();
    periods[0] = 62;  // about -3%
    periods[1] = 66;  // about +3%
    foreach (periods[p]) begin
      send_good(8'h81, periods[p]);
      send_good(8'($urandom_range(0, 255)), periods[p]);
      drive_bit(1'b1, BIT_CLKS);
    end
    wait_idle("baud");
    checks += 2;
    if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL baud_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    if (ferr_seen !== 0) begin failures++; $display("FAIL baud_ferr: got %0d required 0", ferr_seen); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL baud_byte%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    clear_sb();
    // Upper nibble and stop are 1 so the line stays high once reset releases.
    b = 8'hF0 | 8'($urandom_range(0, 15));
    fork
      send_frame(b, 1'b1, BIT_CLKS);
      begin
        repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        checks++;
        if (bus.o_rx_busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before: got %b required 1", bus.o_rx_busy); end
        rst = 1'b1;
        @(negedge clk);
        checks += 4;
        if (bus.o_rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_data: got %h required 00", bus.o_rx_data); end
        if (bus.o_rx_done !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b required 0", bus.o_rx_done); end
        if (bus.o_frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_ferr: got %b required 0", bus.o_frame_err); end
        if (bus.o_rx_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b required 0", bus.o_rx_busy); end
        rst = 1'b0;
        last_data = 8'h00;
      end
    join
    wait_idle("rstmid");
    checks += 2;
    if (obs_q.size() !== 0 || ferr_seen !== 0) begin failures++; $display("FAIL rstmid_discard: got %0d done %0d ferr required 0 0", obs_q.size(), ferr_seen); end
    if (bus.o_rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_hold: got %h required 00", bus.o_rx_data); end
    send_good(8'h12, BIT_CLKS);
    wait_idle("rstmid");
    checks += 2;
    if (obs_q.size() !== 1) begin failures++; $display("FAIL rstmid_next_count: got %0d required 1", obs_q.size()); end
    else if (obs_q[0] !== 8'h12) begin failures++; $display("FAIL rstmid_next_byte: got %h required 12", obs_q[0]); end
    if (bus.o_rx_data !== 8'h12) begin failures++; $display("FAIL rstmid_next_hold: got %h required 12", bus.o_rx_data); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_valid_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_baud_tolerance();
    test_reset_mid_frame();
    checks++;
    if (both_seen !== 0) begin failures++; $display("FAIL done_and_ferr_overlap: got %0d required 0", both_seen); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
